puf_crp_sequencer: RTL

//  Drives the 8-bit arbiter PUF array: accepts a challenge on a valid/ready input, holds it on the PUF

---
 rtl/puf_pkg.sv | 15 +
 rtl/puf_vote_counter.sv | 27 ++
 rtl/puf_crp_sequencer.sv | 79 +++++++
 3 files changed

// File: rtl/puf_pkg.sv
// puf_pkg: FSM state codes, default bus widths and a clog2 helper shared by the PUF CRP sequencer.
package puf_pkg;
   localparam int DEF_CHAL_W = 8;
   localparam int DEF_RESP_W = 8;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARM  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/puf_vote_counter.sv
// puf_vote_counter: counts ones seen on one response bit across evaluations; majority and instability flags.
// PUF_UNSTABLE_MASK_EN enables the instability comparator, otherwise unstable_o is tied low.
module puf_vote_counter import puf_pkg::*; #(
   parameter int NUM_EVAL = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic inc_i,
   output logic majority_o,
   output logic unstable_o
);
   localparam int VW = clog2(NUM_EVAL + 1);
   localparam logic [VW-1:0] HALF = VW'(NUM_EVAL / 2);
   logic [VW-1:0] cnt_q, cnt_d;
   assign cnt_d = clr_i ? '0 : cnt_q + VW'(inc_i);
   always_ff @(posedge clk)
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign majority_o = cnt_q > HALF;
`ifdef PUF_UNSTABLE_MASK_EN
   localparam logic [VW-1:0] ALL = VW'(NUM_EVAL);
   assign unstable_o = (cnt_q != '0) && (cnt_q != ALL);
`else
   assign unstable_o = 1'b0;
`endif
endmodule

// File: rtl/puf_crp_sequencer.sv
// puf_crp_sequencer: arms/launches the arbiter PUF NUM_EVAL times per challenge and emits a majority-voted CRP.
// PUF_UNSTABLE_MASK_EN drives out_unstable with the per-bit instability mask; otherwise it reads zero.
module puf_crp_sequencer import puf_pkg::*; #(
   parameter int CHAL_W     = DEF_CHAL_W,
   parameter int RESP_W     = DEF_RESP_W,
   parameter int NUM_EVAL   = 5,
   parameter int SETTLE_CYC = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CHAL_W-1:0] in_chal,
   output logic [CHAL_W-1:0] puf_challenge,
   output logic              puf_en,
   input  logic [RESP_W-1:0] puf_response,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CHAL_W-1:0] out_chal,
   output logic [RESP_W-1:0] out_resp,
   output logic [RESP_W-1:0] out_unstable
);
   if (NUM_EVAL < 1 || NUM_EVAL % 2 == 0) begin : g_bad_eval
      $error("NUM_EVAL must be odd and >= 1");
   end
   if (SETTLE_CYC < 1) begin : g_bad_settle
      $error("SETTLE_CYC must be >= 1");
   end
   localparam int EW = clog2(NUM_EVAL + 1);
   localparam int SW = clog2(SETTLE_CYC + 1);
   localparam logic [EW-1:0] LAST_EVAL = EW'(NUM_EVAL - 1);
   localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE_CYC - 1);
   logic [1:0]        state_q, state_d;
   logic [EW-1:0]     eval_q, eval_d;
   logic [SW-1:0]     settle_q, settle_d;
   logic [CHAL_W-1:0] chal_q, chal_d;
   logic [RESP_W-1:0] maj, unst;
   logic              accept, sample;
   assign in_ready  = state_q == S_IDLE;
   assign puf_en    = state_q == S_WAIT;
   assign out_valid = state_q == S_DONE;
   assign accept    = in_valid && in_ready;
   assign sample    = puf_en && settle_q == LAST_SETTLE;
   always_comb begin
      state_d  = state_q == S_IDLE ? (in_valid ? S_ARM : S_IDLE)
               : state_q == S_ARM  ? S_WAIT
               : state_q == S_WAIT ? (sample ? (eval_q == LAST_EVAL ? S_DONE : S_ARM) : S_WAIT)
               : (out_ready ? S_IDLE : S_DONE);
      settle_d = state_q == S_ARM ? '0 : puf_en ? settle_q + 1'b1 : settle_q;
      eval_d   = accept ? '0 : sample ? eval_q + 1'b1 : eval_q;
      chal_d   = accept ? in_chal : chal_q;
   end
   always_ff @(posedge clk)
      if (rst) begin
         state_q  <= S_IDLE;
         eval_q   <= '0;
         settle_q <= '0;
         chal_q   <= '0;
      end else begin
         state_q  <= state_d;
         eval_q   <= eval_d;
         settle_q <= settle_d;
         chal_q   <= chal_d;
      end
   for (genvar i = 0; i < RESP_W; i++) begin : g_vote
      puf_vote_counter #(.NUM_EVAL(NUM_EVAL)) u_vote (
         .clk        (clk),
         .rst        (rst),
         .clr_i      (accept),
         .inc_i      (sample && puf_response[i]),
         .majority_o (maj[i]),
         .unstable_o (unst[i])
      );
   end
   assign puf_challenge = chal_q;
   assign out_chal      = chal_q;
   assign out_resp      = maj;
   assign out_unstable  = unst;
endmodule
